data_path: RTL and testbench

- 32-bit single-bus CPU datapath, controlled each cycle by an external control-signal vector (testbench or control unit).
- Contains: sixteen general registers R0–R15, PC, IR, MAR, MDR, Y, 64-bit Z, HI, LO, and an RB jump-target register.
- Contains a bus encoder/multiplexer and a combinational ALU.
- Sits between the control unit and the memory interface; memory read data enters on Mdatain.

---
 rtl/data_path_if.sv | 33 +++
 rtl/data_path.sv | 152 +++++++++++++++
 tb/tb_data_path.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_path_if.sv
// Control/data bundle between a control unit (master) and the single-bus datapath (slave).
// Latency: none, wires only.
// Backpressure: none; control vectors are sampled every rising edge.
interface data_path_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] Mdatain;
    logic [15:0]      ALUControl;
    logic [31:0]      Rin;
    logic [31:0]      Rout;
    logic             IRin;
    logic             MARin;
    logic             RZout;
    logic             RYin;
    logic             RBin;
    logic             PCjump;
    logic             MDRread;
    logic [WIDTH-1:0] BusMuxOut;
    logic [WIDTH-1:0] IRout;
    logic [WIDTH-1:0] MARout;

    modport master (
        output Mdatain, ALUControl, Rin, Rout, IRin, MARin, RZout,
               RYin, RBin, PCjump, MDRread,
        input  BusMuxOut, IRout, MARout
    );

    modport slave (
        input  Mdatain, ALUControl, Rin, Rout, IRin, MARin, RZout,
               RYin, RBin, PCjump, MDRread,
        output BusMuxOut, IRout, MARout
    );
endinterface

// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: register file, special registers, bus mux and combinational ALU.
// Latency: register transfers land on the next rising edge; ALU result reaches the bus one cycle after Zin.
// Backpressure: none; the control vector is obeyed every cycle.
module data_path #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input  logic        i_clock,
    input  logic        i_clear,
    data_path_if.slave  io_dp
);
    // Shared Rin/Rout bit positions above the general registers
    localparam int ID_HI  = 16;
    localparam int ID_LO  = 17;
    localparam int ID_ZH  = 18;
    localparam int ID_ZL  = 19;
    localparam int ID_PC  = 20;
    localparam int ID_MDR = 21;
    localparam int NSRC   = 22;
    localparam int SHW    = $clog2(WIDTH);

    logic [WIDTH-1:0]   r_gpr [NREGS];
    logic [WIDTH-1:0]   r_hi, r_lo, r_pc, r_ir, r_mar, r_mdr, r_y, r_rb;
    logic [2*WIDTH-1:0] r_z;

    logic [WIDTH-1:0]   w_src [NSRC];
    logic [NSRC-1:0]    w_sel;
    logic [WIDTH-1:0]   w_bus;
    logic [2*WIDTH-1:0] w_alu;
    logic               w_zin;

    // Bits 22-31 of the bit map carry no register
    logic w_unused_bits;
    assign w_unused_bits = ^{io_dp.Rin[31:NSRC], io_dp.Rout[31:NSRC]};

    // RZout is an alias for the Z-low select
    assign w_sel = {io_dp.Rout[ID_MDR:ID_PC],
                    io_dp.Rout[ID_ZL] | io_dp.RZout,
                    io_dp.Rout[ID_ZH:0]};
    assign w_zin = io_dp.Rin[ID_ZH] | io_dp.Rin[ID_ZL];

    // Gather every bus source into one indexable array
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            w_src[i] = r_gpr[i];
        end
        w_src[ID_HI]  = r_hi;
        w_src[ID_LO]  = r_lo;
        w_src[ID_ZH]  = r_z[2*WIDTH-1:WIDTH];
        w_src[ID_ZL]  = r_z[WIDTH-1:0];
        w_src[ID_PC]  = r_pc;
        w_src[ID_MDR] = r_mdr;
    end

    // Priority bus mux: scanning downward lets the lowest asserted select win
    always_comb begin
        w_bus = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                w_bus = w_src[i];
            end
        end
    end

    // ALU operand helpers
    logic [SHW-1:0]           w_shamt;
    logic [2*WIDTH-1:0]       w_rot_r, w_rot_l;
    logic signed [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod;
    logic [WIDTH-1:0]         w_div_b;
    logic signed [WIDTH-1:0]  w_quo, w_rem;

    assign w_shamt = w_bus[SHW-1:0];
    assign w_rot_r = {r_y, r_y} >> w_shamt;
    assign w_rot_l = {r_y, r_y} << w_shamt;
    assign w_a_ext = {{WIDTH{r_y[WIDTH-1]}}, r_y};
    assign w_b_ext = {{WIDTH{w_bus[WIDTH-1]}}, w_bus};
    assign w_prod  = w_a_ext * w_b_ext;
    // Divisor forced nonzero so the divider never sees 0; the result is masked below
    assign w_div_b = (w_bus == '0) ? WIDTH'(1) : w_bus;
    assign w_quo   = $signed(r_y) / $signed(w_div_b);
    assign w_rem   = $signed(r_y) % $signed(w_div_b);

    // ALU: A = Y, B = bus; 32-bit results zero-extend into the high word
    always_comb begin
        w_alu = '0;
        case (io_dp.ALUControl)
            16'd0:  w_alu = {{WIDTH{1'b0}}, w_bus + WIDTH'(1)};
            16'd1:  w_alu = {{WIDTH{1'b0}}, r_y & w_bus};
            16'd2:  w_alu = {{WIDTH{1'b0}}, r_y | w_bus};
            16'd3:  w_alu = {{WIDTH{1'b0}}, r_y + w_bus};
            16'd4:  w_alu = {{WIDTH{1'b0}}, r_y - w_bus};
            16'd5:  w_alu = {{WIDTH{1'b0}}, r_y >> w_shamt};
            16'd6:  w_alu = {{WIDTH{1'b0}}, r_y << w_shamt};
            16'd7:  w_alu = {{WIDTH{1'b0}}, $unsigned($signed(r_y) >>> w_shamt)};
            16'd8:  w_alu = {{WIDTH{1'b0}}, w_rot_r[WIDTH-1:0]};
            16'd9:  w_alu = {{WIDTH{1'b0}}, w_rot_l[2*WIDTH-1:WIDTH]};
            16'd10: w_alu = {{WIDTH{1'b0}}, {WIDTH{1'b0}} - w_bus};
            16'd11: w_alu = {{WIDTH{1'b0}}, ~w_bus};
            16'd12: w_alu = $unsigned(w_prod);
            16'd13: w_alu = (w_bus == '0) ? '0 : {$unsigned(w_rem), $unsigned(w_quo)};
            default: w_alu = '0;
        endcase
    end

    // General registers load from the bus
    always_ff @(posedge i_clock) begin
        for (int i = 0; i < NREGS; i++) begin
            if (i_clear) begin
                r_gpr[i] <= '0;
            end else if (io_dp.Rin[i]) begin
                r_gpr[i] <= w_bus;
            end
        end
    end

    // HI, LO, Z and MDR
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_z   <= '0;
            r_mdr <= '0;
        end else begin
            if (io_dp.Rin[ID_HI]) r_hi <= w_bus;
            if (io_dp.Rin[ID_LO]) r_lo <= w_bus;
            if (w_zin)            r_z  <= w_alu;
            if (io_dp.Rin[ID_MDR]) r_mdr <= io_dp.MDRread ? io_dp.Mdatain : w_bus;
        end
    end

    // PC (jump from RB takes priority over a bus load), IR, MAR, Y, RB
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_pc  <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_y   <= '0;
            r_rb  <= '0;
        end else begin
            if (io_dp.PCjump)          r_pc <= r_rb;
            else if (io_dp.Rin[ID_PC]) r_pc <= w_bus;
            if (io_dp.IRin)  r_ir  <= w_bus;
            if (io_dp.MARin) r_mar <= w_bus;
            if (io_dp.RYin)  r_y   <= w_bus;
            if (io_dp.RBin)  r_rb  <= w_bus;
        end
    end

    assign io_dp.BusMuxOut = w_bus;
    assign io_dp.IRout     = r_ir;
    assign io_dp.MARout    = r_mar;
endmodule

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: stimulus queues expected bus/IR/MAR values, a monitor compares them.
// Latency: observation cycles are checked on the falling edge within the same cycle.
// Backpressure: none.
module tb_data_path;
    localparam int W = 32;

    logic clock = 1'b0;
    logic clear = 1'b0;
    always #5 clock = ~clock;

    data_path_if #(.WIDTH(W)) u_if ();

    data_path #(.WIDTH(W), .NREGS(16)) dut (
        .i_clock (clock),
        .i_clear (clear),
        .io_dp   (u_if)
    );

    typedef struct {
        string       name;
        int          kind;   // 0 = BusMuxOut, 1 = IRout, 2 = MARout
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    logic [31:0] mon_act;
    logic obs_vld = 1'b0;
    int tests = 0;
    int fails = 0;

    function automatic logic [31:0] b(input int n);
        return 32'h1 << n;
    endfunction

    task automatic idle();
        u_if.Mdatain    = '0;
        u_if.ALUControl = '0;
        u_if.Rin        = '0;
        u_if.Rout       = '0;
        u_if.IRin       = 1'b0;
        u_if.MARin      = 1'b0;
        u_if.RZout      = 1'b0;
        u_if.RYin       = 1'b0;
        u_if.RBin       = 1'b0;
        u_if.PCjump     = 1'b0;
        u_if.MDRread    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
        obs_vld = 1'b0;
    endtask

    task automatic observe(input string nm, input int kind, input logic [31:0] rout,
                           input logic rz, input logic [31:0] exp);
        exp_t e;
        e.name = nm;
        e.kind = kind;
        e.exp  = exp;
        sb_q.push_back(e);
        u_if.Rout  = rout;
        u_if.RZout = rz;
        obs_vld    = 1'b1;
        tick();
    endtask

    task automatic load_mdr(input logic [31:0] v);
        u_if.Mdatain = v;
        u_if.MDRread = 1'b1;
        u_if.Rin     = b(21);
        tick();
    endtask

    task automatic load_reg(input int idx, input logic [31:0] v);
        load_mdr(v);
        u_if.Rout = b(21);
        u_if.Rin  = b(idx);
        tick();
    endtask

    task automatic alu(input string nm, input logic [15:0] code, input logic [31:0] y,
                       input logic [31:0] bv, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        load_mdr(y);
        u_if.Rout = b(21);
        u_if.RYin = 1'b1;
        tick();
        load_mdr(bv);
        u_if.Rout       = b(21);
        u_if.ALUControl = code;
        u_if.Rin        = b(19);
        tick();
        observe({nm, "_zlo"}, 0, b(19), 1'b0, exp_lo);
        observe({nm, "_zhi"}, 0, b(18), 1'b0, exp_hi);
    endtask

    // Monitor: whenever an observation cycle is presented, pop and compare
    always @(negedge clock) begin
        if (obs_vld) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL monitor: observation with empty scoreboard");
            end else begin
                mon_e = sb_q.pop_front();
                case (mon_e.kind)
                    1:       mon_act = u_if.IRout;
                    2:       mon_act = u_if.MARout;
                    default: mon_act = u_if.BusMuxOut;
                endcase
                if (mon_act !== mon_e.exp) begin
                    fails++;
                    $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // Put nonzero state everywhere reachable so the reset check means something
        load_reg(3, 32'hDEADBEEF);
        load_reg(16, 32'h11111111);
        load_mdr(32'h55);
        u_if.Rout = b(21); u_if.RYin = 1'b1; u_if.RBin = 1'b1; u_if.IRin = 1'b1;
        u_if.MARin = 1'b1; u_if.Rin = b(20) | b(19);
        u_if.ALUControl = 16'd0;
        tick();

        // Reset with random enables: clear must override every load
        clear = 1'b1;
        u_if.Rin        = $urandom | b(21);
        u_if.Rout       = $urandom;
        u_if.Mdatain    = $urandom | 32'h1;
        u_if.MDRread    = 1'b1;
        u_if.ALUControl = 16'd3;
        u_if.IRin = 1'b1; u_if.MARin = 1'b1; u_if.RYin = 1'b1;
        u_if.RBin = 1'b1; u_if.PCjump = 1'b1;
        tick();
        clear = 1'b0;

        observe("rst_bus_idle", 0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 22; i++) begin
            observe($sformatf("rst_src%0d", i), 0, b(i), 1'b0, 32'h0);
        end
        observe("rst_ir", 1, 32'h0, 1'b0, 32'h0);
        observe("rst_mar", 2, 32'h0, 1'b0, 32'h0);
        // Y reaches Z through ADD with an idle bus; RB reaches PC through a jump
        u_if.ALUControl = 16'd3; u_if.Rin = b(19);
        tick();
        observe("rst_y", 0, 32'h0, 1'b1, 32'h0);
        u_if.PCjump = 1'b1;
        tick();
        observe("rst_rb", 0, b(20), 1'b0, 32'h0);

        // Register loads through MDR
        load_reg(5, 32'h34);
        observe("load_r5", 0, b(5), 1'b0, 32'h34);
        load_reg(6, 32'h45);
        observe("load_r6", 0, b(6), 1'b0, 32'h45);
        load_reg(2, 32'h67);
        observe("load_r2", 0, b(2), 1'b0, 32'h67);

        // Instruction fetch
        u_if.Rout = b(20); u_if.MARin = 1'b1; u_if.Rin = b(19); u_if.ALUControl = 16'd0;
        tick();
        observe("fetch_mar", 2, 32'h0, 1'b0, 32'h0);
        observe("fetch_zlo", 0, b(19), 1'b0, 32'h1);
        u_if.RZout = 1'b1; u_if.Rin = b(20) | b(21);
        u_if.Mdatain = 32'h112B0000; u_if.MDRread = 1'b1;
        tick();
        observe("fetch_pc", 0, b(20), 1'b0, 32'h1);
        observe("fetch_mdr", 0, b(21), 1'b0, 32'h112B0000);
        u_if.Rout = b(21); u_if.IRin = 1'b1;
        tick();
        observe("fetch_ir", 1, 32'h0, 1'b0, 32'h112B0000);

        // AND R5, R6 into R2
        u_if.Rout = b(5); u_if.RYin = 1'b1;
        tick();
        u_if.Rout = b(6); u_if.ALUControl = 16'd1; u_if.Rin = b(19);
        tick();
        observe("and_zlo", 0, b(19), 1'b0, 32'h04);
        u_if.RZout = 1'b1; u_if.Rin = b(2);
        tick();
        observe("and_r2", 0, b(2), 1'b0, 32'h04);

        // ALU table (name, code, Y, B, Z low, Z high)
        alu("add_wrap", 16'd3,  32'hFFFFFFFF, 32'h1,        32'h0,        32'h0);
        alu("mul",      16'd12, 32'h00010000, 32'h00010000, 32'h0,        32'h1);
        alu("div0",     16'd13, 32'h7,        32'h0,        32'h0,        32'h0);
        alu("sub",      16'd4,  32'h5,        32'h7,        32'hFFFFFFFE, 32'h0);
        alu("shr",      16'd5,  32'h80000000, 32'h4,        32'h08000000, 32'h0);
        alu("shl",      16'd6,  32'h1,        32'h1F,       32'h80000000, 32'h0);
        alu("shra",     16'd7,  32'h80000000, 32'h4,        32'hF8000000, 32'h0);
        alu("ror",      16'd8,  32'h1,        32'h1,        32'h80000000, 32'h0);
        alu("rol",      16'd9,  32'h80000001, 32'h1,        32'h00000003, 32'h0);
        alu("neg",      16'd10, 32'h0,        32'h1,        32'hFFFFFFFF, 32'h0);
        alu("not",      16'd11, 32'h0,        32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0);
        alu("or",       16'd2,  32'hF0,       32'h0F,       32'hFF,       32'h0);
        alu("mul_neg",  16'd12, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 32'hFFFFFFFF);
        alu("div_neg",  16'd13, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF);
        alu("inc",      16'd0,  32'h0,        32'h41,       32'h42,       32'h0);
        alu("bad_code", 16'd14, 32'h5,        32'h5,        32'h0,        32'h0);

        // Jump has priority over a PC bus load
        load_mdr(32'h100);
        u_if.Rout = b(21); u_if.RBin = 1'b1;
        tick();
        load_mdr(32'h200);
        u_if.Rout = b(21); u_if.PCjump = 1'b1; u_if.Rin = b(20);
        tick();
        observe("jump_pc", 0, b(20), 1'b0, 32'h100);
        u_if.Rout = b(21); u_if.Rin = b(20);
        tick();
        observe("pcin_pc", 0, b(20), 1'b0, 32'h200);

        // Bus priority and unused selects
        observe("prio_r5_r6", 0, b(5) | b(6), 1'b0, 32'h34);
        observe("prio_r5_rz", 0, b(5), 1'b1, 32'h34);
        observe("unused_rout", 0, b(22) | b(31), 1'b0, 32'h0);
        observe("prio_mdr_unused", 0, b(21) | b(30), 1'b0, 32'h200);

        // One source feeding several destinations, including itself
        u_if.Rout = b(2); u_if.Rin = b(2) | b(7) | b(8);
        tick();
        observe("multi_r7", 0, b(7), 1'b0, 32'h04);
        observe("multi_r8", 0, b(8), 1'b0, 32'h04);
        observe("multi_r2", 0, b(2), 1'b0, 32'h04);

        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
